// File: rtl/sram_1rw1r_param.sv
// Parameterised 1RW + 1R synchronous SRAM model with per-lane write mask,
// optional output register stage, and a post-reset zero-fill sequencer.
module sram_1rw1r_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned MASK_GRAN  = 8,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               csb0,
    input  logic                               web0,
    input  logic [DATA_WIDTH/MASK_GRAN-1:0]    wmask0,
    input  logic [ADDR_WIDTH-1:0]              addr0,
    input  logic [DATA_WIDTH-1:0]              din0,
    output logic [DATA_WIDTH-1:0]              dout0,
    output logic                               dout0_valid,
    input  logic                               csb1,
    input  logic [ADDR_WIDTH-1:0]              addr1,
    output logic [DATA_WIDTH-1:0]              dout1,
    output logic                               dout1_valid,
    output logic                               busy
);

    localparam int unsigned NUM_WMASKS = DATA_WIDTH / MASK_GRAN;
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    if ((DATA_WIDTH % MASK_GRAN) != 0) begin : g_bad_mask_gran
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of MASK_GRAN");
    end

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_en;
    logic                  rd0_en;
    logic                  rd1_en;
    logic [DATA_WIDTH-1:0] rd1_word;

    logic [DATA_WIDTH-1:0] rd0_q;
    logic [DATA_WIDTH-1:0] rd1_q;
    logic                  rd0_v;
    logic                  rd1_v;

    // Requests only count in READY; anything presented while clearing is dropped.
    assign wr_en  = (state == READY) && !rst && !csb0 && !web0;
    assign rd0_en = (state == READY) && !csb0 && web0;
    assign rd1_en = (state == READY) && !csb1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (INIT_CLEAR != 0) ? CLEAR : READY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (cnt == ADDR_WIDTH'(DEPTH - 1)) state_next = READY;
            READY:   state_next = READY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= (INIT_CLEAR != 0);
        end else begin
            if (state == CLEAR) cnt <= cnt + ADDR_WIDTH'(1);
            busy <= (state_next == CLEAR);
        end
    end

    // Array: zero-fill while clearing, otherwise lane-masked port-0 writes.
    always_ff @(posedge clk) begin
        if ((state == CLEAR) && !rst) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) mem[addr0][i*MASK_GRAN +: MASK_GRAN] <= din0[i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    // Port-1 sees the post-write word when it collides with a port-0 write.
    always_comb begin
        rd1_word = mem[addr1];
        if (wr_en && (addr0 == addr1)) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) rd1_word[i*MASK_GRAN +: MASK_GRAN] = din0[i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_q <= '0;
            rd1_q <= '0;
            rd0_v <= 1'b0;
            rd1_v <= 1'b0;
        end else begin
            rd0_v <= rd0_en;
            rd1_v <= rd1_en;
            if (rd0_en) rd0_q <= mem[addr0];
            if (rd1_en) rd1_q <= rd1_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out0_q;
        logic [DATA_WIDTH-1:0] out1_q;
        logic                  out0_v;
        logic                  out1_v;

        // Second stage only advances when the first stage holds fresh data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out0_q <= '0;
                out1_q <= '0;
                out0_v <= 1'b0;
                out1_v <= 1'b0;
            end else begin
                out0_v <= rd0_v;
                out1_v <= rd1_v;
                if (rd0_v) out0_q <= rd0_q;
                if (rd1_v) out1_q <= rd1_q;
            end
        end

        assign dout0       = out0_q;
        assign dout1       = out1_q;
        assign dout0_valid = out0_v;
        assign dout1_valid = out1_v;
    end else begin : g_no_out_reg
        assign dout0       = rd0_q;
        assign dout1       = rd1_q;
        assign dout0_valid = rd0_v;
        assign dout1_valid = rd1_v;
    end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench for sram_1rw1r_param: three configurations share one
// random stimulus stream and are checked against an array-level reference model.
module tb_sram_1rw1r_param;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csb0 = 1'b1;
    logic        web0 = 1'b1;
    logic [3:0]  wmask0 = '0;
    logic [3:0]  addr0 = '0;
    logic [63:0] din0 = '0;
    logic        csb1 = 1'b1;
    logic [3:0]  addr1 = '0;

    logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
    logic [63:0] c_dout0, c_dout1;
    logic        a_v0, a_v1, b_v0, b_v1, c_v0, c_v1;
    logic        a_busy, b_busy, c_busy;

    // A: 32b/8b lanes, no output reg. B: same with output reg. C: 64b/16b lanes, output reg.
    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .MASK_GRAN(8), .OUT_REG(0), .INIT_CLEAR(1)) dut_a (
        .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0[31:0]),
        .dout0(a_dout0), .dout0_valid(a_v0), .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dout1_valid(a_v1),
        .busy(a_busy));

    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .MASK_GRAN(8), .OUT_REG(1), .INIT_CLEAR(1)) dut_b (
        .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0[31:0]),
        .dout0(b_dout0), .dout0_valid(b_v0), .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dout1_valid(b_v1),
        .busy(b_busy));

    sram_1rw1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(AW), .MASK_GRAN(16), .OUT_REG(1), .INIT_CLEAR(1)) dut_c (
        .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(c_dout0), .dout0_valid(c_v0), .csb1(csb1), .addr1(addr1), .dout1(c_dout1), .dout1_valid(c_v1),
        .busy(c_busy));

    logic [31:0] m32 [DEPTH];
    logic [63:0] m64 [DEPTH];
    logic [63:0] last [6];
    exp_t        sb [$];
    int          cyc = 0;
    int          clear_left = DEPTH;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Zero-fill takes one edge per word once reset is released.
    always @(posedge clk or posedge rst) begin
        if (rst) clear_left <= DEPTH;
        else if (clear_left > 0) clear_left <= clear_left - 1;
    end

    // Reset kills in-flight reads and leaves the array zero once clearing finishes.
    always @(posedge rst) begin
        sb.delete();
        for (int i = 0; i < 6; i++) last[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m32[i] = '0;
            m64[i] = '0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input logic [63:0] data, input int lat);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.due  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic port_chk(input int id, input logic v, input logic [63:0] d);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].id == id) begin
                idx = i;
                break;
            end
        end
        if (v) begin
            if (idx < 0) begin
                chk($sformatf("unexpected_valid_p%0d", id), 64'd1, 64'd0);
            end else begin
                chk($sformatf("data_p%0d", id), d, sb[idx].data);
                chk($sformatf("latency_p%0d", id), 64'(cyc), 64'(sb[idx].due));
                last[id] = sb[idx].data;
                sb.delete(idx);
            end
        end else begin
            chk($sformatf("hold_p%0d", id), d, last[id]);
            if (idx >= 0 && sb[idx].due <= cyc) begin
                chk($sformatf("missing_valid_p%0d", id), 64'd0, 64'd1);
                sb.delete(idx);
            end
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            port_chk(0, a_v0, 64'(a_dout0));
            port_chk(1, a_v1, 64'(a_dout1));
            port_chk(2, b_v0, 64'(b_dout0));
            port_chk(3, b_v1, 64'(b_dout1));
            port_chk(4, c_v0, c_dout0);
            port_chk(5, c_v1, c_dout1);
            chk("busy_a", 64'(a_busy), 64'(clear_left != 0));
            chk("busy_b", 64'(b_busy), 64'(clear_left != 0));
            chk("busy_c", 64'(c_busy), 64'(clear_left != 0));
        end
    end

    task automatic reset_chk();
        chk("rst_a_dout0", 64'(a_dout0), 64'd0);
        chk("rst_a_dout1", 64'(a_dout1), 64'd0);
        chk("rst_b_dout0", 64'(b_dout0), 64'd0);
        chk("rst_b_dout1", 64'(b_dout1), 64'd0);
        chk("rst_c_dout0", c_dout0, 64'd0);
        chk("rst_c_dout1", c_dout1, 64'd0);
        chk("rst_valids", 64'({a_v0, a_v1, b_v0, b_v1, c_v0, c_v1}), 64'd0);
        chk("rst_busy", 64'({a_busy, b_busy, c_busy}), 64'h7);
    endtask

    // Present one request for the next edge and record what the model expects from it.
    task automatic drive(input logic c0, input logic w0, input logic [3:0] m, input logic [3:0] a0,
                         input logic [63:0] d, input logic c1, input logic [3:0] a1);
        @(negedge clk);
        csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
        if (!rst && clear_left == 0) begin
            if (!c0 && !w0) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) begin
                        m32[a0][i*8 +: 8]   = d[i*8 +: 8];
                        m64[a0][i*16 +: 16] = d[i*16 +: 16];
                    end
                end
            end
            if (!c0 && w0) begin
                push(0, 64'(m32[a0]), 1);
                push(2, 64'(m32[a0]), 2);
                push(4, m64[a0], 2);
            end
            if (!c1) begin
                push(1, 64'(m32[a1]), 1);
                push(3, 64'(m32[a1]), 2);
                push(5, m64[a1], 2);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 4'h0, 4'h0, 64'h0, 1'b1, 4'h0);
    endtask

    task automatic rand_op();
        drive(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
              {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0), 4'($urandom));
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 4'h0, 4'(i), 64'h0, 1'b0, 4'(DEPTH - 1 - i));
        idle(3);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_chk();
        @(negedge clk);
        #1 rst = 1'b0;

        // Requests during the clear window, including its last edge, must vanish.
        for (int i = 0; i < DEPTH - 1; i++) rand_op();
        idle(2);
        read_all();

        // Partial-lane write over an existing word, then read both ports.
        drive(1'b0, 1'b0, 4'hF, 4'd5, 64'h5566_7788_1122_3344, 1'b1, 4'd0);
        drive(1'b0, 1'b0, 4'b0101, 4'd5, 64'h99AA_BBCC_AABB_CCDD, 1'b1, 4'd0);
        drive(1'b0, 1'b1, 4'h0, 4'd5, 64'h0, 1'b0, 4'd5);
        idle(3);

        // Same-edge write and port-1 read of one address.
        drive(1'b0, 1'b0, 4'hF, 4'd7, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 4'd7);
        idle(3);

        // Top lane only.
        drive(1'b0, 1'b0, 4'hF, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        drive(1'b0, 1'b0, 4'b1000, 4'd3, 64'h0123_4567_89AB_CDEF, 1'b1, 4'd0);
        drive(1'b0, 1'b1, 4'h0, 4'd3, 64'h0, 1'b0, 4'd3);
        idle(3);

        // Empty mask is a no-op.
        drive(1'b0, 1'b0, 4'h0, 4'd3, 64'h0, 1'b0, 4'd3);
        idle(3);

        for (int i = 0; i < 400; i++) rand_op();
        idle(4);

        // Reset just after a read edge: nothing from that read may surface afterwards.
        drive(1'b0, 1'b1, 4'h0, 4'd5, 64'h0, 1'b0, 4'd7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 reset_chk();
        @(negedge clk);
        #2 rst = 1'b0;

        // Reset again once the clear counter has reached 9; clearing restarts from 0.
        for (int i = 0; i < 9; i++) rand_op();
        #2 rst = 1'b1;
        #1 reset_chk();
        @(negedge clk);
        #2 rst = 1'b0;
        idle(DEPTH + 2);
        read_all();

        for (int i = 0; i < 200; i++) rand_op();
        idle(4);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
